yarp_regfile_sb: RTL and testbench
==================================

Name: yarp_regfile_sb

Overview:
Parametrised integer register file with a configurable number of combinational read ports, one write port, an optional write-to-read bypass, and a per-register pending-write scoreboard. Sits between decode/issue and writeback in the YARP core. Issue allocates a destination; writeback clears it. The scoreboard lets the core stall on RAW hazards against long-latency results such as loads and multi-cycle ALU ops.

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREGS), register address width (derived; do not override)
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes and cannot be allocated
BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  core clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
rs_addr_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rs_data_o  out  NRD*XLEN  read data, port k at bits [k*XLEN +: XLEN]
rs_busy_o  out  NRD  port k source has an outstanding (pending) write
wr_en_i  in  1  writeback strobe
wr_addr_i  in  AW  writeback destination
wr_data_i  in  XLEN  writeback data
alloc_en_i  in  1  issue requests destination allocation
alloc_addr_i  in  AW  destination to allocate
alloc_ok_o  out  1  allocation accepted this cycle (combinational)
flush_i  in  1  clear every pending bit (pipeline flush)
pend_cnt_o  out  $clog2(NREGS+1)  registered count of pending registers

Behaviour:
- Reset (async, reset_n=0): all registers = 0, all pending bits = 0, pend_cnt_o = 0. Combinational outputs follow from this state: rs_data_o = 0, rs_busy_o = 0.
- Reset mid-operation clears everything immediately. No write, allocation or flush in progress survives.
- Write: on posedge with wr_en_i=1, reg[wr_addr_i] <= wr_data_i. If ZERO_REG=1 and wr_addr_i=0, the write is dropped.
- Read: combinational, zero latency. rs_data_o[k] = reg[rs_addr_i[k]].
  - ZERO_REG=1 and address 0 -> reads 0.
  - BYPASS=1, wr_en_i=1, wr_addr_i = rs_addr_i[k], and the address is writable -> rs_data_o[k] = wr_data_i.
  - BYPASS=0 -> the old value is returned until the following cycle.
- Scoreboard pending bit per register, updated on posedge:
  - Cleared by a write to that address.
  - Set by an accepted allocation.
  - If clear and set hit the same address in the same cycle, set wins and the bit stays 1. This is a new producer replacing the retiring one.
- alloc_ok_o = alloc_en_i & !flush_i & !(ZERO_REG & alloc_addr_i==0) & (!pend[alloc_addr_i] | (wr_en_i & wr_addr_i==alloc_addr_i)).
  - Allocating an already-pending register is refused (WAW stall) unless it retires in the same cycle.
- rs_busy_o[k] = pend[rs_addr_i[k]] & !(wr_en_i & wr_addr_i==rs_addr_i[k]).
  - When BYPASS=0, the term after & is removed, so busy holds until the bit has cleared.
  - Register 0 is never busy when ZERO_REG=1.
- flush_i=1: all pending bits <= 0 next edge, and any allocation in that cycle is refused. A write in the same cycle still updates data.
- pend_cnt_o: registered popcount of the pending vector. It reflects the pending state after each edge, i.e. next-state popcount registered. Range 0..NREGS (NREGS-1 when ZERO_REG=1), no wrap.
- Write with no pending bit set is legal: data updates, scoreboard is unchanged.
- Read ports are independent. Identical addresses on several ports return identical data and busy.

Test Plan:
- Reset then read all regs on both ports -> all 0, rs_busy_o=00, pend_cnt_o=0. Assert reset_n=0 mid-sequence after writes -> regs 0 immediately.
- Write x5=0xDEADBEEF with rs_addr[0]=5 same cycle -> rs_data_o[0]=0xDEADBEEF same cycle (BYPASS=1). Next cycle port1 reads 5 -> 0xDEADBEEF.
- Write x0=0x12345678, then read x0 -> 0. alloc x0 -> alloc_ok_o=0, pend_cnt_o stays 0.
- Alloc x7 -> ok=1, next cycle busy on port reading 7, pend_cnt_o=1. Alloc x7 again -> ok=0. wr x7=0x55 -> busy drops same cycle, pend_cnt_o=0 after edge.
- Pending x9, then same-cycle wr x9=0xA and alloc x9 -> ok=1, x9 reads 0xA, busy stays 1, pend_cnt_o=1.
- Alloc x1,x2,x3 -> pend_cnt_o=3. flush_i with alloc x4 -> ok=0, next cycle pend_cnt_o=0, all busy 0. Repeat with BYPASS=0, NRD=3 build -> same-cycle write read returns old value.

Source files
------------

// File: rtl/yarp_regfile_sb_if.sv
// ---------------------------------------------------------------------------
// yarp_regfile_sb_if
// Bundle of the register-file / scoreboard signals shared between the
// issue/writeback side of the core (master) and the register file (slave).
//   rs_addr_i   : NRD packed read addresses, port k at [k*AW +: AW]
//   rs_data_o   : NRD packed read data, port k at [k*XLEN +: XLEN]
//   rs_busy_o   : per-port "source has an outstanding write"
//   wr_en_i / wr_addr_i / wr_data_i : writeback port
//   alloc_en_i / alloc_addr_i / alloc_ok_o : destination allocation
//   flush_i     : clear all pending bits
//   pend_cnt_o  : registered number of pending registers
// ---------------------------------------------------------------------------
interface yarp_regfile_sb_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(NREGS),
  parameter int CW    = $clog2(NREGS + 1)
);
  logic [NRD*AW-1:0]   rs_addr_i;
  logic [NRD*XLEN-1:0] rs_data_o;
  logic [NRD-1:0]      rs_busy_o;
  logic                wr_en_i;
  logic [AW-1:0]       wr_addr_i;
  logic [XLEN-1:0]     wr_data_i;
  logic                alloc_en_i;
  logic [AW-1:0]       alloc_addr_i;
  logic                alloc_ok_o;
  logic                flush_i;
  logic [CW-1:0]       pend_cnt_o;

  modport master (
    output rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_en_i, alloc_addr_i, flush_i,
    input  rs_data_o, rs_busy_o, alloc_ok_o, pend_cnt_o
  );

  modport slave (
    input  rs_addr_i, wr_en_i, wr_addr_i, wr_data_i,
           alloc_en_i, alloc_addr_i, flush_i,
    output rs_data_o, rs_busy_o, alloc_ok_o, pend_cnt_o
  );
endinterface

// File: rtl/yarp_regfile_sb.sv
// ---------------------------------------------------------------------------
// yarp_regfile_sb
// Integer register file with NRD combinational read ports, one write port,
// optional write-to-read bypass and a per-register pending-write scoreboard
// used by issue to stall on RAW/WAW hazards.
// Ports:
//   clk     : core clock, state updates on rising edge
//   reset_n : asynchronous active-low reset (clears data, pending, count)
//   bus     : yarp_regfile_sb_if slave modport (read, write, alloc, flush)
// ---------------------------------------------------------------------------
module yarp_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int AW       = $clog2(NREGS),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int CW       = $clog2(NREGS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  yarp_regfile_sb_if.slave  bus
);

  logic [XLEN-1:0]     regs_r [NREGS];
  logic [NREGS-1:0]    pend_r;
  logic [CW-1:0]       cnt_r;

  logic                wr_ok_s;
  logic                alloc_zero_s;
  logic                alloc_ok_s;
  logic [NREGS-1:0]    pend_nxt_s;
  logic [CW-1:0]       cnt_nxt_s;
  logic [NRD*XLEN-1:0] rd_data_s;
  logic [NRD-1:0]      rd_busy_s;

  // Register 0 is hard-wired when ZERO_REG is set: writes and allocations to it are dropped.
  assign wr_ok_s      = bus.wr_en_i & !((ZERO_REG != 0) && (bus.wr_addr_i == {AW{1'b0}}));
  assign alloc_zero_s = (ZERO_REG != 0) && (bus.alloc_addr_i == {AW{1'b0}});
  // A pending destination may be re-allocated only when it retires in the same cycle.
  assign alloc_ok_s   = bus.alloc_en_i & !bus.flush_i & !alloc_zero_s &
                        (!pend_r[bus.alloc_addr_i] |
                         (bus.wr_en_i & (bus.wr_addr_i == bus.alloc_addr_i)));

  // Read ports: zero register, then same-cycle bypass, then array contents.
  always_comb begin
    rd_data_s = {(NRD*XLEN){1'b0}};
    rd_busy_s = {NRD{1'b0}};
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0] ra;
      logic          wr_hit;
      ra     = bus.rs_addr_i[k*AW +: AW];
      wr_hit = bus.wr_en_i & (bus.wr_addr_i == ra);
      if ((ZERO_REG != 0) && (ra == {AW{1'b0}})) begin
        rd_data_s[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy_s[k]              = 1'b0;
      end else if (BYPASS != 0) begin
        rd_data_s[k*XLEN +: XLEN] = wr_hit ? bus.wr_data_i : regs_r[ra];
        rd_busy_s[k]              = pend_r[ra] & !wr_hit;
      end else begin
        rd_data_s[k*XLEN +: XLEN] = regs_r[ra];
        rd_busy_s[k]              = pend_r[ra];
      end
    end
  end

  // Scoreboard next state: flush clears all; otherwise write clears, then allocation sets (set wins).
  always_comb begin
    pend_nxt_s = pend_r;
    if (bus.flush_i) begin
      pend_nxt_s = {NREGS{1'b0}};
    end else begin
      if (bus.wr_en_i) begin
        pend_nxt_s[bus.wr_addr_i] = 1'b0;
      end else begin
        pend_nxt_s = pend_nxt_s;
      end
      if (alloc_ok_s) begin
        pend_nxt_s[bus.alloc_addr_i] = 1'b1;
      end else begin
        pend_nxt_s = pend_nxt_s;
      end
    end
  end

  // Popcount of the next pending vector, so the registered count tracks the post-edge state.
  always_comb begin
    cnt_nxt_s = {CW{1'b0}};
    for (int i = 0; i < NREGS; i++) begin
      cnt_nxt_s = cnt_nxt_s + {{(CW-1){1'b0}}, pend_nxt_s[i]};
    end
  end

  // Register array write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else if (wr_ok_s) begin
      regs_r[bus.wr_addr_i] <= bus.wr_data_i;
    end
  end

  // Scoreboard and pending-count state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r <= {NREGS{1'b0}};
      cnt_r  <= {CW{1'b0}};
    end else begin
      pend_r <= pend_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  assign bus.rs_data_o  = rd_data_s;
  assign bus.rs_busy_o  = rd_busy_s;
  assign bus.alloc_ok_o = alloc_ok_s;
  assign bus.pend_cnt_o = cnt_r;

endmodule

// File: tb/tb_yarp_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_yarp_regfile_sb
// Directed bench for yarp_regfile_sb: instance A (NRD=2, BYPASS=1) is
// driven from a vector table; instance B (NRD=3, BYPASS=0) and the
// mid-run reset are covered by short hand-written sequences.
// ---------------------------------------------------------------------------
module tb_yarp_regfile_sb;

  logic clk;
  logic reset_n;

  yarp_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(2)) bus_a ();
  yarp_regfile_sb_if #(.XLEN(32), .NREGS(32), .NRD(3)) bus_b ();

  yarp_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  yarp_regfile_sb #(.XLEN(32), .NREGS(32), .NRD(3), .ZERO_REG(1), .BYPASS(0)) u_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        alloc_en;
    logic [4:0]  alloc_addr;
    logic        flush;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic [1:0]  e_busy;
    logic        e_ok;
    logic [5:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    bus_a.rs_addr_i = '0; bus_a.wr_en_i = 1'b0; bus_a.wr_addr_i = '0; bus_a.wr_data_i = '0;
    bus_a.alloc_en_i = 1'b0; bus_a.alloc_addr_i = '0; bus_a.flush_i = 1'b0;
    bus_b.rs_addr_i = '0; bus_b.wr_en_i = 1'b0; bus_b.wr_addr_i = '0; bus_b.wr_data_i = '0;
    bus_b.alloc_en_i = 1'b0; bus_b.alloc_addr_i = '0; bus_b.flush_i = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_all();
    reset_n = 1'b0;

    //             wen  wa      wd             aen  aa     fl   ra0    ra1    d0             d1             busy   ok    cnt
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd0,  5'd1,  32'h0,        32'h0,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd5,  5'd6,  32'hDEADBEEF, 32'h0,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd6,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b0, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b0, 5'd7,  5'd5,  32'h0,        32'hDEADBEEF, 2'b01, 1'b0, 6'd1});
    vecs.push_back('{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  1'b0, 5'd7,  5'd7,  32'h55,       32'h55,       2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd7,  32'h0,        32'h55,       2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b1, 5'd9,  32'hA,        1'b1, 5'd9,  1'b0, 5'd9,  5'd9,  32'hA,        32'hA,        2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd9,  5'd1,  32'hA,        32'h0,        2'b01, 1'b0, 6'd1});
    vecs.push_back('{1'b1, 5'd9,  32'hB,        1'b0, 5'd0,  1'b0, 5'd9,  5'd9,  32'hB,        32'hB,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd1,  1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd2,  1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b01, 1'b1, 6'd2});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd1,  5'd2,  32'h0,        32'h0,        2'b11, 1'b1, 6'd3});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b1, 5'd3,  5'd4,  32'h0,        32'h0,        2'b01, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd1,  5'd3,  32'h0,        32'h0,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b1, 5'd12, 32'h77,       1'b0, 5'd0,  1'b0, 5'd12, 5'd3,  32'h77,       32'h0,        2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd13, 1'b0, 5'd13, 5'd12, 32'h0,        32'h77,       2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b1, 5'd13, 32'h99,       1'b1, 5'd14, 1'b1, 5'd13, 5'd13, 32'h99,       32'h99,       2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  1'b0, 5'd13, 5'd12, 32'h99,       32'h77,       2'b00, 1'b0, 6'd0});
    vecs.push_back('{1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 1'b0, 5'd0,  5'd0,  32'h0,        32'h0,        2'b00, 1'b1, 6'd1});
    vecs.push_back('{1'b1, 5'd20, 32'h1,        1'b1, 5'd21, 1'b0, 5'd20, 5'd21, 32'h1,        32'h0,        2'b00, 1'b1, 6'd1});

    // Reset state: every register on both ports of A reads zero, nothing busy.
    #12;
    reset_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      bus_a.rs_addr_i = {i[4:0], i[4:0]};
      #1;
      chk($sformatf("reset_rd_x%0d", i), bus_a.rs_data_o[31:0] | bus_a.rs_data_o[63:32], 32'h0);
    end
    chk("reset_busy", {30'h0, bus_a.rs_busy_o}, 32'h0);
    chk("reset_cnt", {26'h0, bus_a.pend_cnt_o}, 32'h0);
    chk("reset_cnt_b", {26'h0, bus_b.pend_cnt_o}, 32'h0);

    // Table-driven sequence on instance A.
    @(posedge clk); #1;
    for (int v = 0; v < vecs.size(); v++) begin
      bus_a.wr_en_i      = vecs[v].wr_en;
      bus_a.wr_addr_i    = vecs[v].wr_addr;
      bus_a.wr_data_i    = vecs[v].wr_data;
      bus_a.alloc_en_i   = vecs[v].alloc_en;
      bus_a.alloc_addr_i = vecs[v].alloc_addr;
      bus_a.flush_i      = vecs[v].flush;
      bus_a.rs_addr_i    = {vecs[v].ra1, vecs[v].ra0};
      #2;
      chk($sformatf("v%0d_d0", v), bus_a.rs_data_o[31:0], vecs[v].e_d0);
      chk($sformatf("v%0d_d1", v), bus_a.rs_data_o[63:32], vecs[v].e_d1);
      chk($sformatf("v%0d_busy", v), {30'h0, bus_a.rs_busy_o}, {30'h0, vecs[v].e_busy});
      chk($sformatf("v%0d_ok", v), {31'h0, bus_a.alloc_ok_o}, {31'h0, vecs[v].e_ok});
      @(posedge clk); #1;
      chk($sformatf("v%0d_cnt", v), {26'h0, bus_a.pend_cnt_o}, {26'h0, vecs[v].e_cnt});
    end

    // Mid-run async reset: x9=0xB, x12=0x77, x21 pending; all must clear without a clock edge.
    idle_all();
    bus_a.rs_addr_i = {5'd12, 5'd9};
    #1;
    chk("pre_rst_d0", bus_a.rs_data_o[31:0], 32'hB);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_d0", bus_a.rs_data_o[31:0], 32'h0);
    chk("mid_rst_d1", bus_a.rs_data_o[63:32], 32'h0);
    chk("mid_rst_cnt", {26'h0, bus_a.pend_cnt_o}, 32'h0);
    bus_a.rs_addr_i = {5'd21, 5'd21};
    #1;
    chk("mid_rst_busy", {30'h0, bus_a.rs_busy_o}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Instance B (no bypass, three ports): same-cycle write returns the old value.
    @(posedge clk); #1;
    bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd5; bus_b.wr_data_i = 32'h11;
    bus_b.rs_addr_i = {5'd0, 5'd5, 5'd5};
    #2;
    chk("b_nobyp_d0", bus_b.rs_data_o[31:0], 32'h0);
    chk("b_nobyp_d1", bus_b.rs_data_o[63:32], 32'h0);
    @(posedge clk); #1;
    bus_b.wr_en_i = 1'b0;
    bus_b.rs_addr_i = {5'd5, 5'd5, 5'd5};
    bus_b.alloc_en_i = 1'b1; bus_b.alloc_addr_i = 5'd6;
    #2;
    chk("b_d0", bus_b.rs_data_o[31:0], 32'h11);
    chk("b_d1", bus_b.rs_data_o[63:32], 32'h11);
    chk("b_d2", bus_b.rs_data_o[95:64], 32'h11);
    chk("b_ok", {31'h0, bus_b.alloc_ok_o}, 32'h1);
    @(posedge clk); #1;
    chk("b_cnt1", {26'h0, bus_b.pend_cnt_o}, 32'h1);
    bus_b.alloc_en_i = 1'b0;
    bus_b.wr_en_i = 1'b1; bus_b.wr_addr_i = 5'd6; bus_b.wr_data_i = 32'h22;
    bus_b.rs_addr_i = {5'd6, 5'd0, 5'd5};
    #2;
    chk("b_busy_hold", {29'h0, bus_b.rs_busy_o}, 32'h4);
    chk("b_old_d2", bus_b.rs_data_o[95:64], 32'h0);
    @(posedge clk); #1;
    bus_b.wr_en_i = 1'b0;
    bus_b.rs_addr_i = {5'd6, 5'd6, 5'd6};
    #2;
    chk("b_cnt0", {26'h0, bus_b.pend_cnt_o}, 32'h0);
    chk("b_busy_clr", {29'h0, bus_b.rs_busy_o}, 32'h0);
    chk("b_new_d0", bus_b.rs_data_o[31:0], 32'h22);
    chk("b_new_d2", bus_b.rs_data_o[95:64], 32'h22);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
